// File: rtl/systolic_ws_ctrl.sv
// Sequencer for a weight-stationary systolic array: loads a weight tile, skews
// per-lane source reads into the west edge and de-skews per-column result writes.
module systolic_ws_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_NUM    = 8,
  parameter int COL_NUM    = 8,
  parameter int LENGTH     = 8,
  parameter int ARRAY_LAT  = 8,
  localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      keep_weights,
  input  logic [ROW_ADDR_WIDTH:0]   num_rows,
  output logic                      busy,
  output logic                      done,
  input  logic                      w_val,
  output logic                      w_rdy,
  input  logic [DATA_WIDTH-1:0]     w_row      [0:COL_NUM-1],
  output logic [DATA_WIDTH-1:0]     weights    [0:LENGTH-1][0:COL_NUM-1],
  output logic                      src_rd_en  [0:LENGTH-1],
  output logic [ROW_ADDR_WIDTH-1:0] src_rdaddr [0:LENGTH-1],
  input  logic [DATA_WIDTH-1:0]     src_data   [0:LENGTH-1],
  output logic [DATA_WIDTH-1:0]     west_data  [0:LENGTH-1],
  output logic                      dst_wr_en  [0:COL_NUM-1],
  output logic [ROW_ADDR_WIDTH-1:0] dst_wraddr [0:COL_NUM-1],
  output logic [1:0]                dbg_state_o
);

  // Last useful cycle of a row is whichever is later: the final lane read or
  // the last column write after the array latency.
  localparam int FILL_SPAN = ARRAY_LAT + COL_NUM;
  localparam int MAX_SPAN  = (LENGTH - 1 > FILL_SPAN) ? LENGTH - 1 : FILL_SPAN;
  localparam int T_W       = $clog2(ROW_NUM + MAX_SPAN + 1);
  localparam int WC_W      = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int NR_W      = ROW_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [WC_W-1:0]     w_cnt_q, w_cnt_d;
  logic [NR_W-1:0]     n_q, n_d;
  logic [DATA_WIDTH-1:0] weights_q [0:LENGTH-1][0:COL_NUM-1];
  logic                rd_en_q   [0:LENGTH-1];

  logic                w_beat;
  logic [NR_W-1:0]     n_sat;
  logic [T_W-1:0]      n_t;
  logic [T_W-1:0]      t_last;
  logic [T_W:0]        lane_dt [0:LENGTH-1];
  logic [T_W:0]        col_dt  [0:COL_NUM-1];

  assign n_sat  = (num_rows > NR_W'(ROW_NUM)) ? NR_W'(ROW_NUM) : num_rows;
  assign n_t    = T_W'(n_q);
  assign t_last = n_t + T_W'(MAX_SPAN - 1);

  // Weight rows use valid/ready: a beat transfers on the cycle where w_val and
  // w_rdy are both high; w_rdy depends only on state, never on w_val.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    w_cnt_d = w_cnt_q;
    n_d     = n_q;
    w_beat  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d = n_sat;
          if (keep_weights) begin
            t_d     = '0;
            state_d = (n_sat == '0) ? DONE : STREAM;
          end else begin
            w_cnt_d = '0;
            state_d = LOAD_W;
          end
        end
      end
      LOAD_W: begin
        if (w_val) begin
          w_beat  = 1'b1;
          w_cnt_d = w_cnt_q + 1'b1;
          if (w_cnt_q == WC_W'(LENGTH - 1)) begin
            t_d     = '0;
            state_d = (n_q == '0) ? DONE : STREAM;
          end
        end
      end
      STREAM: begin
        if (t_q == t_last) begin
          state_d = DONE;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      w_cnt_q <= '0;
      n_q     <= '0;
      for (int r = 0; r < LENGTH; r++) begin
        for (int c = 0; c < COL_NUM; c++) begin
          weights_q[r][c] <= '0;
        end
      end
      for (int k = 0; k < LENGTH; k++) begin
        rd_en_q[k] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      w_cnt_q <= w_cnt_d;
      n_q     <= n_d;
      for (int r = 0; r < LENGTH; r++) begin
        if (w_beat && (w_cnt_q == WC_W'(r))) begin
          for (int c = 0; c < COL_NUM; c++) begin
            weights_q[r][c] <= w_row[c];
          end
        end
      end
      for (int k = 0; k < LENGTH; k++) begin
        rd_en_q[k] <= src_rd_en[k];
      end
    end
  end

  // Skew/de-skew decode: offsets are computed one bit wider so a negative
  // difference shows up as the sign bit instead of wrapping into range.
  always_comb begin
    for (int k = 0; k < LENGTH; k++) begin
      lane_dt[k]    = {1'b0, t_q} - (T_W + 1)'(k);
      src_rd_en[k]  = 1'b0;
      src_rdaddr[k] = '0;
      if ((state_q == STREAM) && !lane_dt[k][T_W] && (lane_dt[k][T_W-1:0] < n_t)) begin
        src_rd_en[k]  = 1'b1;
        src_rdaddr[k] = ROW_ADDR_WIDTH'(lane_dt[k][T_W-1:0]);
      end
    end
    for (int c = 0; c < COL_NUM; c++) begin
      col_dt[c]     = {1'b0, t_q} - (T_W + 1)'(1 + ARRAY_LAT + c);
      dst_wr_en[c]  = 1'b0;
      dst_wraddr[c] = '0;
      if ((state_q == STREAM) && !col_dt[c][T_W] && (col_dt[c][T_W-1:0] < n_t)) begin
        dst_wr_en[c]  = 1'b1;
        dst_wraddr[c] = ROW_ADDR_WIDTH'(col_dt[c][T_W-1:0]);
      end
    end
  end

  // Idle lanes present exact zeros so skew fill adds nothing to partial sums.
  always_comb begin
    for (int k = 0; k < LENGTH; k++) begin
      west_data[k] = rd_en_q[k] ? src_data[k] : '0;
    end
    for (int r = 0; r < LENGTH; r++) begin
      for (int c = 0; c < COL_NUM; c++) begin
        weights[r][c] = weights_q[r][c];
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign w_rdy       = (state_q == LOAD_W);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_systolic_ws_ctrl.sv
// Randomized bench for systolic_ws_ctrl: per-job event schedule derived from
// row timing (row r hits lane k at r+k, column c at r+1+LAT+c).
module tb_systolic_ws_ctrl;
  localparam int DW = 32, RN = 8, CN = 4, LEN = 4, LAT = 4, AW = 3, MAXT = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start, keep_weights, busy, done, w_val, w_rdy;
  logic [AW:0]   num_rows;
  logic [DW-1:0] w_row      [0:CN-1];
  logic [DW-1:0] weights    [0:LEN-1][0:CN-1];
  logic          src_rd_en  [0:LEN-1];
  logic [AW-1:0] src_rdaddr [0:LEN-1];
  logic [DW-1:0] src_data   [0:LEN-1];
  logic [DW-1:0] west_data  [0:LEN-1];
  logic          dst_wr_en  [0:CN-1];
  logic [AW-1:0] dst_wraddr [0:CN-1];
  logic [1:0]    dbg_state;

  systolic_ws_ctrl #(
    .DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN), .LENGTH(LEN), .ARRAY_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .keep_weights(keep_weights),
    .num_rows(num_rows), .busy(busy), .done(done), .w_val(w_val), .w_rdy(w_rdy),
    .w_row(w_row), .weights(weights), .src_rd_en(src_rd_en), .src_rdaddr(src_rdaddr),
    .src_data(src_data), .west_data(west_data), .dst_wr_en(dst_wr_en),
    .dst_wraddr(dst_wraddr), .dbg_state_o(dbg_state)
  );

  // model state
  logic [DW-1:0] w_model [0:LEN-1][0:CN-1];
  logic [DW-1:0] mem     [0:LEN-1][0:RN-1];
  int            exp_rd  [0:MAXT-1][0:LEN-1];
  int            exp_wv  [0:MAXT-1][0:LEN-1];
  logic [15:0]   exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_src(input bit ff_fill);
    for (int k = 0; k < LEN; k++) begin
      if (src_rd_en[k] === 1'b1) src_data[k] = mem[k][src_rdaddr[k]];
      else                       src_data[k] = ff_fill ? '1 : $urandom;
    end
  endtask

  task automatic noise_start();
    start        = 1'($urandom_range(0, 1));
    keep_weights = 1'($urandom_range(0, 1));
    num_rows     = 4'($urandom_range(0, 15));
  endtask

  task automatic check_quiet(input string tag);
    for (int k = 0; k < LEN; k++) begin
      check($sformatf("%s lane%0d_en", tag, k), src_rd_en[k], 0);
      check($sformatf("%s lane%0d_addr", tag, k), src_rdaddr[k], 0);
      check($sformatf("%s west%0d", tag, k), west_data[k], 0);
    end
    for (int c = 0; c < CN; c++) begin
      check($sformatf("%s col%0d_en", tag, c), dst_wr_en[c], 0);
      check($sformatf("%s col%0d_addr", tag, c), dst_wraddr[c], 0);
    end
  endtask

  task automatic check_weights(input string tag);
    for (int r = 0; r < LEN; r++)
      for (int c = 0; c < CN; c++)
        check($sformatf("%s w[%0d][%0d]", tag, r, c), weights[r][c], w_model[r][c]);
  endtask

  task automatic check_west(input int t);
    for (int k = 0; k < LEN; k++)
      check($sformatf("west%0d t=%0d", k, t), west_data[k],
            (exp_wv[t][k] >= 0) ? mem[k][exp_wv[t][k]] : 0);
  endtask

  task automatic run_job(input bit keep, input int nreq, input bit stall, input bit rgap,
                         input bit ff_fill, input int abort_t);
    int n, t_last, beats, stall_left, guard;
    logic [15:0] ev;
    bit found, exp_on;
    n = (nreq > RN) ? RN : nreq;
    t_last = -1;
    exp_q.delete();
    for (int t = 0; t < MAXT; t++)
      for (int k = 0; k < LEN; k++) begin
        exp_rd[t][k] = -1;
        exp_wv[t][k] = -1;
      end
    for (int k = 0; k < LEN; k++)
      for (int r = 0; r < RN; r++) mem[k][r] = $urandom;
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k < LEN; k++) begin
        exp_rd[r + k][k]     = r;
        exp_wv[r + k + 1][k] = r;
        if (r + k > t_last) t_last = r + k;
      end
      for (int c = 0; c < CN; c++) begin
        exp_q.push_back({8'(r + 1 + LAT + c), 4'(c), 4'(r)});
        if (r + 1 + LAT + c > t_last) t_last = r + 1 + LAT + c;
      end
    end

    @(negedge clk);
    start = 1'b1; keep_weights = keep; num_rows = 4'(nreq);
    @(negedge clk);

    if (!keep) begin
      beats = 0; stall_left = 0; guard = 0;
      while (beats < LEN) begin
        check("load w_rdy", w_rdy, 1);
        check("load busy", busy, 1);
        check("load done", done, 0);
        check_quiet("load");
        noise_start();
        w_val = 1'b1;
        if (stall_left > 0) begin
          w_val = 1'b0;
          stall_left--;
        end else if (rgap && guard < 40 && $urandom_range(0, 2) == 0) begin
          w_val = 1'b0;
        end
        guard++;
        if (w_val) begin
          for (int c = 0; c < CN; c++) begin
            w_row[c] = $urandom;
            w_model[beats][c] = w_row[c];
          end
          beats++;
          if (stall && beats == 2) stall_left = 2;
        end
        drive_src(ff_fill);
        @(negedge clk);
      end
      w_val = 1'b0;
    end
    check_weights("held");

    for (int t = 0; t <= t_last; t++) begin
      check($sformatf("stream busy t=%0d", t), busy, 1);
      check($sformatf("stream done t=%0d", t), done, 0);
      check($sformatf("stream w_rdy t=%0d", t), w_rdy, 0);
      for (int k = 0; k < LEN; k++) begin
        exp_on = (exp_rd[t][k] >= 0);
        check($sformatf("lane%0d_en t=%0d", k, t), src_rd_en[k], exp_on);
        check($sformatf("lane%0d_addr t=%0d", k, t), src_rdaddr[k], exp_on ? exp_rd[t][k] : 0);
      end
      check_west(t);
      for (int c = 0; c < CN; c++) begin
        if (dst_wr_en[c] === 1'b1) begin
          ev = {8'(t), 4'(c), 1'b0, dst_wraddr[c]};
          found = 1'b0;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i] == ev) begin
              exp_q.delete(i);
              found = 1'b1;
              break;
            end
          end
          check($sformatf("col%0d_wr addr=%0d t=%0d expected", c, dst_wraddr[c], t), found, 1);
        end else begin
          check($sformatf("col%0d_addr idle t=%0d", c, t), dst_wraddr[c], 0);
        end
      end
      if (t == abort_t) begin
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst w_rdy", w_rdy, 0);
        check_quiet("rst");
        for (int r = 0; r < LEN; r++)
          for (int c = 0; c < CN; c++) w_model[r][c] = '0;
        check_weights("rst");
        reset = 1'b0;
        return;
      end
      noise_start();
      drive_src(ff_fill);
      @(negedge clk);
    end

    check("done pulse", done, 1);
    check("done busy", busy, 1);
    check("done w_rdy", w_rdy, 0);
    check_west(t_last + 1);
    check("writes outstanding", exp_q.size(), 0);
    noise_start();
    drive_src(ff_fill);
    @(negedge clk);
    check("idle done", done, 0);
    check("idle busy", busy, 0);
    check_quiet("idle");
    start = 1'b0;
    drive_src(ff_fill);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; keep_weights = 1'b0; num_rows = '0; w_val = 1'b0;
    for (int c = 0; c < CN; c++) w_row[c] = '0;
    for (int k = 0; k < LEN; k++) src_data[k] = '1;
    for (int r = 0; r < LEN; r++)
      for (int c = 0; c < CN; c++) w_model[r][c] = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset w_rdy", w_rdy, 0);
    check_quiet("reset");
    check_weights("reset");
    reset = 1'b0;

    run_job(1'b0, 3, 1'b1, 1'b0, 1'b1, -1);
    run_job(1'b1, 8, 1'b0, 1'b0, 1'b0, -1);
    run_job(1'b1, 0, 1'b0, 1'b0, 1'b1, -1);
    run_job(1'b0, 0, 1'b0, 1'b1, 1'b0, -1);
    run_job(1'b1, 12, 1'b0, 1'b0, 1'b1, -1);
    run_job(1'b1, 3, 1'b0, 1'b0, 1'b1, 5);
    run_job(1'b1, 2, 1'b0, 1'b0, 1'b0, -1);
    for (int j = 0; j < 8; j++) begin
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              1'b1, 1'($urandom_range(0, 1)), -1);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
